// File: rtl/u_div32.sv
// Sequential unsigned radix-2 restoring divider with a start/done handshake.
// One quotient bit is resolved per clock; results hold until the next request.
module u_div32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [0:0]       state;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] quot_sr;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   next_partial;
  logic [WIDTH-1:0] next_quot;

  // One restoring step: bring in the next dividend bit, try to subtract.
  // NOTE: combinational logic uses blocking assignments with every output
  // given a value on every path, so no latches are inferred.
  always_comb begin
    shifted      = {partial[WIDTH-1:0], dividend[WIDTH-1]};
    trial        = shifted - {1'b0, divisor};
    next_partial = shifted;
    next_quot    = {quot_sr[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      next_partial = trial;
      next_quot    = {quot_sr[WIDTH-2:0], 1'b1};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dividend    <= '0;
      divisor     <= '0;
      partial     <= '0;
      quot_sr     <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dividend    <= src1;
            divisor     <= src2;
            partial     <= '0;
            quot_sr     <= '0;
            count       <= '0;
            div_by_zero <= (src2 == '0);
            busy        <= 1'b1;
            state       <= CALC;
          end
        end
        CALC: begin
          partial  <= next_partial;
          quot_sr  <= next_quot;
          dividend <= {dividend[WIDTH-2:0], 1'b0};
          count    <= count + 1'b1;
          if (count == LAST_ITER) begin
            quotient  <= next_quot;
            remainder <= next_partial[WIDTH-1:0];
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_u_div32.sv
// Directed and randomized checks for u_div32: latency, edge operands,
// divide by zero, ignored start, back-to-back requests and mid-operation reset.
module tb_u_div32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        busy;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  u_div32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src1       (src1),
    .src2       (src2),
    .quotient   (quotient),
    .remainder  (remainder),
    .done       (done),
    .busy       (busy),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; returns at the falling edge after E0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    src1  = a;
    src2  = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts rising edges from the accepting edge until done is seen (bounded).
  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (done) break;
    end
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int k;
    start_op(a, b);
    check({tag, " busy"}, 64'(busy), 64'd1);
    wait_done(0, k);
    check({tag, " latency"}, 64'(k), 64'd32);
    check({tag, " quotient"}, 64'(quotient), 64'(eq));
    check({tag, " remainder"}, 64'(remainder), 64'(er));
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({tag, " done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int k;
    int seen;
    logic [31:0] a;
    logic [31:0] b;

    rst = 1'b1; start = 1'b0; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset quotient", 64'(quotient), 64'd0);
    check("reset remainder", 64'(remainder), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset dbz", 64'(div_by_zero), 64'd0);

    do_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    do_div("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_div("5/max", 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b0);
    do_div("0/3", 32'd0, 32'd3, 32'd0, 32'd0, 1'b0);
    do_div("1234/0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1);

    // Start during a running division is ignored; operands may change freely.
    start_op(32'd81, 32'd9);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b1; src1 = 32'd50; src2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; src1 = 32'd0; src2 = 32'd0;
    wait_done(10, k);
    check("ignore latency", 64'(k), 64'd32);
    check("ignore quotient", 64'(quotient), 64'd9);
    check("ignore remainder", 64'(remainder), 64'd0);
    // Back-to-back: request presented while done is visible.
    start_op(32'd50, 32'd3);
    check("b2b done_low", 64'(done), 64'd0);
    wait_done(0, k);
    check("b2b latency", 64'(k), 64'd32);
    check("b2b quotient", 64'(quotient), 64'd16);
    check("b2b remainder", 64'(remainder), 64'd2);
    @(negedge clk);

    // Reset at E15 abandons the division.
    start_op(32'd1000, 32'd10);
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst quotient", 64'(quotient), 64'd0);
    check("rst remainder", 64'(remainder), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst dbz", 64'(div_by_zero), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("rst no_done", 64'(seen), 64'd0);
    do_div("1000/10", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);

    // Random pairs checked against the division identity.
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      case (i % 8)
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'($urandom_range(2, 255));
        3:       b = 32'($urandom_range(256, 65535));
        default: b = $urandom;
      endcase
      start_op(a, b);
      wait_done(0, k);
      check("rand latency", 64'(k), 64'd32);
      if (b == 32'd0) begin
        check("rand dbz_flag", 64'(div_by_zero), 64'd1);
        check("rand dbz_quot", 64'(quotient), 64'hFFFF_FFFF);
        check("rand dbz_rem", 64'(remainder), 64'(a));
      end else begin
        check("rand identity", 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
        check("rand rem_lt_div", 64'(remainder < b), 64'd1);
        check("rand dbz_flag", 64'(div_by_zero), 64'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
